// File: rtl/mby_msh_ingress_vc_buf.sv
// Credit-managed ingress buffer: NUM_VC independent FIFOs, round-robin
// arbitration into one registered output stage, one credit per drained entry.

// Single virtual-channel FIFO: storage, pointers and occupancy.
module mby_msh_ingress_vc_fifo #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 64,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic [CNT_W-1:0]  occ
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  occ_q, occ_d;

   // Pointer advance and occupancy update; push+pop together leaves occ as is.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   occ_d = occ_q + CNT_W'(1);
         2'b01:   occ_d = occ_q - CNT_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   // Control state, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Payload storage; contents are only read when occ is non-zero, so no reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign occ     = occ_q;
endmodule

module mby_msh_ingress_vc_buf #(
   parameter  int NUM_VC = 2,
   parameter  int DEPTH  = 8,
   parameter  int DATA_W = 64,
   localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic                    mclk,
   input  logic                    mhreset,
   input  logic                    i_vld,
   input  logic [VC_W-1:0]         i_vc,
   input  logic [DATA_W-1:0]       i_data,
   output logic                    o_vld,
   output logic [VC_W-1:0]         o_vc,
   output logic [DATA_W-1:0]       o_data,
   input  logic                    i_rdy,
   output logic [NUM_VC-1:0]       o_crdt_rtn,
   output logic [NUM_VC*CNT_W-1:0] o_occ,
   output logic                    o_ovfl_err,
   output logic [VC_W-1:0]         o_ovfl_vc
);
   logic [CNT_W-1:0]  occ     [NUM_VC];
   logic [DATA_W-1:0] rd_data [NUM_VC];
   logic [NUM_VC-1:0] push_en, pop_en;
   logic              push_drop;
   logic              stage_free, grant;
   logic [VC_W-1:0]   win;

   logic              o_vld_q, o_vld_d;
   logic [VC_W-1:0]   o_vc_q, o_vc_d;
   logic [DATA_W-1:0] o_data_q, o_data_d;
   logic [NUM_VC-1:0] crdt_q, crdt_d;
   logic [VC_W-1:0]   rr_q, rr_d;
   logic              ovfl_err_q, ovfl_err_d;
   logic [VC_W-1:0]   ovfl_vc_q, ovfl_vc_d;

   for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      mby_msh_ingress_vc_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_fifo (
         .clk     (mclk),
         .rst     (mhreset),
         .push    (push_en[v]),
         .wr_data (i_data),
         .pop     (pop_en[v]),
         .rd_data (rd_data[v]),
         .occ     (occ[v])
      );
      assign o_occ[v*CNT_W +: CNT_W] = occ[v];
   end

   // Push decode on start-of-cycle occupancy; an out-of-range VC matches no FIFO and drops.
   always_comb begin
      push_en = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         if (i_vld && (i_vc == VC_W'(v)) && (occ[v] != CNT_W'(DEPTH))) push_en[v] = 1'b1;
      end
      push_drop = i_vld && (push_en == '0);
   end

   // Round-robin search from rr over non-empty VCs; only granted when the stage frees up.
   always_comb begin
      stage_free = !o_vld_q || i_rdy;
      grant      = 1'b0;
      win        = '0;
      for (int k = 0; k < NUM_VC; k++) begin
         if (!grant && (occ[(int'(rr_q) + k) % NUM_VC] != '0)) begin
            grant = 1'b1;
            win   = VC_W'((int'(rr_q) + k) % NUM_VC);
         end
      end
      grant  = grant && stage_free;
      pop_en = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         if (grant && (win == VC_W'(v))) pop_en[v] = 1'b1;
      end
   end

   // Output stage load/hold/drain, credit pulse and rr advance.
   always_comb begin
      o_vld_d  = o_vld_q;
      o_vc_d   = o_vc_q;
      o_data_d = o_data_q;
      rr_d     = rr_q;
      crdt_d   = pop_en;
      if (grant) begin
         o_vld_d = 1'b1;
         o_vc_d  = win;
         for (int v = 0; v < NUM_VC; v++) begin
            if (pop_en[v]) o_data_d = rd_data[v];
         end
         rr_d = (int'(win) == NUM_VC - 1) ? '0 : win + VC_W'(1);
      end else if (stage_free) begin
         o_vld_d = 1'b0;
      end
   end

   // Sticky overflow flag; the VC is captured only on the first drop.
   always_comb begin
      ovfl_err_d = ovfl_err_q | push_drop;
      ovfl_vc_d  = (push_drop && !ovfl_err_q) ? i_vc : ovfl_vc_q;
   end

   // Output stage, arbiter and error state registers.
   always_ff @(posedge mclk or posedge mhreset) begin
      if (mhreset) begin
         o_vld_q    <= 1'b0;
         o_vc_q     <= '0;
         o_data_q   <= '0;
         crdt_q     <= '0;
         rr_q       <= '0;
         ovfl_err_q <= 1'b0;
         ovfl_vc_q  <= '0;
      end else begin
         o_vld_q    <= o_vld_d;
         o_vc_q     <= o_vc_d;
         o_data_q   <= o_data_d;
         crdt_q     <= crdt_d;
         rr_q       <= rr_d;
         ovfl_err_q <= ovfl_err_d;
         ovfl_vc_q  <= ovfl_vc_d;
      end
   end

   assign o_vld      = o_vld_q;
   assign o_vc       = o_vc_q;
   assign o_data     = o_data_q;
   assign o_crdt_rtn = crdt_q;
   assign o_ovfl_err = ovfl_err_q;
   assign o_ovfl_vc  = ovfl_vc_q;
endmodule

// File: tb/tb_mby_msh_ingress_vc_buf.sv
// Bench for mby_msh_ingress_vc_buf: queue-level reference model, output scoreboard,
// directed scenarios followed by credit-honouring random traffic.
module tb_mby_msh_ingress_vc_buf;
   localparam int NUM_VC = 4;
   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;
   localparam int VC_W   = 2;
   localparam int CNT_W  = 3;

   logic                    mclk = 1'b0;
   logic                    mhreset = 1'b1;
   logic                    i_vld = 1'b0;
   logic [VC_W-1:0]         i_vc = '0;
   logic [DATA_W-1:0]       i_data = '0;
   logic                    i_rdy = 1'b0;
   logic                    o_vld;
   logic [VC_W-1:0]         o_vc;
   logic [DATA_W-1:0]       o_data;
   logic [NUM_VC-1:0]       o_crdt_rtn;
   logic [NUM_VC*CNT_W-1:0] o_occ;
   logic                    o_ovfl_err;
   logic [VC_W-1:0]         o_ovfl_vc;

   mby_msh_ingress_vc_buf #(.NUM_VC(NUM_VC), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .mclk(mclk), .mhreset(mhreset), .i_vld(i_vld), .i_vc(i_vc), .i_data(i_data),
      .o_vld(o_vld), .o_vc(o_vc), .o_data(o_data), .i_rdy(i_rdy),
      .o_crdt_rtn(o_crdt_rtn), .o_occ(o_occ), .o_ovfl_err(o_ovfl_err), .o_ovfl_vc(o_ovfl_vc)
   );

   always #5 mclk = ~mclk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: one queue per VC, a single output slot and a round-robin start.
   typedef struct packed {
      logic [VC_W-1:0]   vc;
      logic [DATA_W-1:0] data;
   } exp_t;

   logic [DATA_W-1:0] mq [NUM_VC][$];
   exp_t              exp_q[$];
   logic              m_vld;
   int                m_vc;
   logic [DATA_W-1:0] m_data;
   logic [NUM_VC-1:0] m_crdt;
   int                m_rr;
   logic              m_err;
   int                m_evc;
   int                ret_cnt [NUM_VC];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int v = 0; v < NUM_VC; v++) mq[v].delete();
      exp_q.delete();
      m_vld = 1'b0; m_vc = 0; m_data = '0; m_crdt = '0; m_rr = 0; m_err = 1'b0; m_evc = 0;
   endtask

   // One clock edge of the buffer's behaviour, from the sampled inputs.
   task automatic model_step(input logic v, input logic [VC_W-1:0] c, input logic [DATA_W-1:0] d,
                             input logic r);
      int  sz [NUM_VC];
      bit  found;
      int  w;
      for (int k = 0; k < NUM_VC; k++) sz[k] = mq[k].size();
      m_crdt = '0;
      if (!m_vld || r) begin
         found = 1'b0;
         w     = 0;
         for (int k = 0; k < NUM_VC; k++) begin
            if (!found && sz[(m_rr + k) % NUM_VC] > 0) begin
               found = 1'b1;
               w     = (m_rr + k) % NUM_VC;
            end
         end
         if (found) begin
            m_vld     = 1'b1;
            m_vc      = w;
            m_data    = mq[w].pop_front();
            m_crdt[w] = 1'b1;
            m_rr      = (w + 1) % NUM_VC;
            exp_q.push_back('{vc: VC_W'(w), data: m_data});
         end else begin
            m_vld = 1'b0;
         end
      end
      if (v) begin
         if (int'(c) < NUM_VC && sz[c] < DEPTH) mq[c].push_back(d);
         else begin
            if (!m_err) m_evc = int'(c);
            m_err = 1'b1;
         end
      end
   endtask

   task automatic check_outputs();
      logic [NUM_VC*CNT_W-1:0] eocc;
      for (int v = 0; v < NUM_VC; v++) eocc[v*CNT_W +: CNT_W] = CNT_W'(mq[v].size());
      chk("o_vld", o_vld, m_vld);
      if (m_vld) begin
         chk("o_vc", o_vc, m_vc);
         chk("o_data", o_data, m_data);
      end
      chk("o_crdt_rtn", o_crdt_rtn, m_crdt);
      chk("o_occ", o_occ, eocc);
      chk("o_ovfl_err", o_ovfl_err, m_err);
      if (m_err) chk("o_ovfl_vc", o_ovfl_vc, m_evc);
   endtask

   // Drive at the falling edge, model the rising edge, check at the next falling edge.
   task automatic cyc(input logic v, input logic [VC_W-1:0] c, input logic [DATA_W-1:0] d,
                      input logic r);
      i_vld = v; i_vc = c; i_data = d; i_rdy = r;
      @(posedge mclk);
      model_step(v, c, d, r);
      @(negedge mclk);
      check_outputs();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_o_vld"}, o_vld, 0);
      chk({tag, "_o_vc"}, o_vc, 0);
      chk({tag, "_o_data"}, o_data, 0);
      chk({tag, "_o_crdt"}, o_crdt_rtn, 0);
      chk({tag, "_o_occ"}, o_occ, 0);
      chk({tag, "_o_ovfl_err"}, o_ovfl_err, 0);
      chk({tag, "_o_ovfl_vc"}, o_ovfl_vc, 0);
   endtask

   // Reset asserted mid-cycle, away from any clock edge; called at a falling edge.
   task automatic mid_reset(input string tag);
      #2 mhreset = 1'b1;
      #1 chk_all_zero(tag);
      model_reset();
      i_vld = 1'b0;
      @(negedge mclk);
      @(negedge mclk);
      #1 mhreset = 1'b0;
      @(negedge mclk);
      check_outputs();
   endtask

   // Scoreboard monitor: every credit pulse marks a newly loaded output entry.
   always @(negedge mclk) begin
      exp_t e;
      if (!mhreset && o_crdt_rtn != '0) begin
         for (int v = 0; v < NUM_VC; v++) if (o_crdt_rtn[v]) ret_cnt[v]++;
         if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL mon_unexpected: got credit %b with empty scoreboard", o_crdt_rtn);
         end else begin
            e = exp_q.pop_front();
            chk("mon_vc", o_vc, e.vc);
            chk("mon_data", o_data, e.data);
            chk("mon_crdt_onehot", o_crdt_rtn, NUM_VC'(1) << e.vc);
         end
      end
   end

   int iss   [NUM_VC];
   int ret0  [NUM_VC];
   int total_push;
   int total_ret;

   initial begin
      for (int v = 0; v < NUM_VC; v++) begin ret_cnt[v] = 0; iss[v] = 0; end
      model_reset();
      #12 chk_all_zero("reset");
      @(negedge mclk);
      #1 mhreset = 1'b0;
      @(negedge mclk);
      check_outputs();

      // Single push to VC1: appears two edges later with a VC1 credit.
      cyc(1'b1, 2'd1, 32'hA5, 1'b1);
      chk("t1_no_bypass", o_vld, 0);
      cyc(1'b0, 2'd0, 32'h0, 1'b1);
      chk("t1_o_vld", o_vld, 1);
      chk("t1_o_vc", o_vc, 1);
      chk("t1_o_data", o_data, 32'hA5);
      chk("t1_crdt", o_crdt_rtn, 4'b0010);
      for (int i = 0; i < 3; i++) cyc(1'b0, 2'd0, 32'h0, 1'b1);
      chk("t1_idle", o_vld, 0);

      // Fill VC0 while stalled, then overflow it twice.
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 2'd0, 32'h100 + i, 1'b0);
      chk("fill_occ", o_occ[CNT_W-1:0], DEPTH - 1);
      cyc(1'b1, 2'd0, 32'h1FE, 1'b0);
      chk("fill_full", o_occ[CNT_W-1:0], DEPTH);
      chk("fill_no_err", o_ovfl_err, 0);
      cyc(1'b1, 2'd0, 32'h1FF, 1'b0);
      chk("ovfl_err", o_ovfl_err, 1);
      chk("ovfl_vc", o_ovfl_vc, 0);
      cyc(1'b1, 2'd3, 32'h2FF, 1'b0);
      cyc(1'b1, 2'd0, 32'h3FF, 1'b0);
      chk("ovfl_vc_held", o_ovfl_vc, 0);
      for (int i = 0; i < 8; i++) cyc(1'b0, 2'd0, 32'h0, 1'b1);
      mid_reset("rst_clr_ovfl");

      // Load VC0 and VC1, then release: output alternates between them.
      for (int i = 0; i < 4; i++) cyc(1'b1, 2'd0, 32'hA000 + i, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 2'd1, 32'hB000 + i, 1'b0);
      for (int i = 0; i < 10; i++) cyc(1'b0, 2'd0, 32'h0, 1'b1);

      // Stall with a valid entry for five cycles, then release.
      for (int i = 0; i < 3; i++) cyc(1'b1, 2'd2, 32'hC000 + i, 1'b1);
      for (int i = 0; i < 5; i++) cyc(1'b0, 2'd0, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 2'd0, 32'h0, 1'b1);

      // Reset while traffic is in flight, then confirm 2-cycle latency again.
      for (int i = 0; i < 4; i++) cyc(1'b1, VC_W'(i), 32'hD000 + i, 1'b1);
      mid_reset("rst_mid");
      cyc(1'b1, 2'd3, 32'h5A5A, 1'b1);
      cyc(1'b0, 2'd0, 32'h0, 1'b1);
      chk("post_rst_data", o_data, 32'h5A5A);
      chk("post_rst_crdt", o_crdt_rtn, 4'b1000);
      for (int i = 0; i < 3; i++) cyc(1'b0, 2'd0, 32'h0, 1'b1);

      // Random traffic within upstream credits.
      for (int v = 0; v < NUM_VC; v++) begin ret0[v] = ret_cnt[v]; iss[v] = 0; end
      for (int n = 0; n < 10000; n++) begin
         logic [VC_W-1:0] c;
         logic            p;
         c = VC_W'($urandom_range(0, NUM_VC - 1));
         p = ($urandom_range(0, 3) != 0) && (DEPTH - (iss[c] - (ret_cnt[c] - ret0[c])) > 0);
         if (p) iss[c]++;
         cyc(p, c, $urandom, $urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < 24; i++) cyc(1'b0, 2'd0, 32'h0, 1'b1);
      total_push = 0;
      total_ret  = 0;
      for (int v = 0; v < NUM_VC; v++) begin
         chk("rand_credits_vc", ret_cnt[v] - ret0[v], iss[v]);
         total_push += iss[v];
         total_ret  += ret_cnt[v] - ret0[v];
      end
      chk("rand_credit_total", total_ret, total_push);
      chk("rand_no_ovfl", o_ovfl_err, 0);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/mby_msh_ingress_vc_buf.md
# mby_msh_ingress_vc_buf

Parametrised, credit-managed ingress buffer for one mesh-node port direction. It holds NUM_VC independent virtual-channel FIFOs, each DEPTH entries deep. It arbitrates round-robin among non-empty VCs into a single registered output stage, and returns one credit per entry drained to the upstream neighbour. It generalises the fixed single-channel request/response credit paths of the mesh node to N channels of configurable width and depth, and adds overflow detection and per-VC occupancy.

## Interface
- NUM_VC, 2: number of virtual channels (1..8).
- DEPTH, 8: entries per VC FIFO (power of 2, 2..64).
- DATA_W, 64: payload width in bits.
- VC_W, derived: (NUM_VC>1) ? $clog2(NUM_VC) : 1.
- CNT_W, derived: $clog2(DEPTH)+1.

Ports:
- mclk  in  1  clock; the only clock.
- mhreset  in  1  reset, asynchronous, active-high.
- i_vld  in  1  upstream push strobe.
- i_vc  in  VC_W  target VC of push.
- i_data  in  DATA_W  push payload.
- o_vld  out  1  output stage holds a valid entry.
- o_vc  out  VC_W  VC of the output entry.
- o_data  out  DATA_W  output payload.
- i_rdy  in  1  downstream accepts the output entry this cycle.
- o_crdt_rtn  out  NUM_VC  one-cycle credit pulse per VC, returned upstream.
- o_occ  out  NUM_VC*CNT_W  per-VC FIFO occupancy; VC v is at [v*CNT_W +: CNT_W].
- o_ovfl_err  out  1  sticky: a push arrived at a full VC.
- o_ovfl_vc  out  VC_W  VC of the first overflow (held until reset).

## Operation
- Reset (async assert, sync release): all FIFOs empty, rr pointer=0. All outputs 0: o_vld, o_vc, o_data, o_crdt_rtn, o_occ, o_ovfl_err, o_ovfl_vc.
- Upstream starts with DEPTH credits per VC after reset. The output register is not credited.
- Push: when i_vld=1 and occ[i_vc]<DEPTH at cycle start, write i_data at wr_ptr[i_vc] and increment occ.
- Fullness uses start-of-cycle occupancy. A push to a full VC is dropped, even if that VC pops in the same cycle.
- Overflow: a dropped push sets o_ovfl_err. The first drop also latches o_ovfl_vc; later drops do not update it.
- i_vc >= NUM_VC: push dropped, treated as overflow with o_ovfl_vc=i_vc.
- Output stage is free when o_vld=0, or when o_vld=1 and i_rdy=1.
- Arbitration runs only when the output stage is free. Search order starts at rr pointer: rr, rr+1, ... mod NUM_VC. The winner is the first VC with occ>0.
- On a grant, the head entry loads the output register, occ decrements, and rr = winner+1 mod NUM_VC.
- No grant: o_vld falls if the current entry was consumed.
- Stall: while o_vld=1 and i_rdy=0, o_vc and o_data hold stable and there is no arbitration.
- Credit: a grant to VC v registers o_crdt_rtn[v]=1 for exactly one cycle.
- Simultaneous push and pop on the same VC: both take effect and occ is unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally. occ uses CNT_W bits so DEPTH is representable.
- No bypass: a pushed entry is never granted in its push cycle.

## Timing
- Push sampled at edge E0. Earliest grant is in the following cycle. o_vld, o_data and o_crdt_rtn[v] rise together after edge E1 (2-cycle latency from the i_vld cycle).
- Back-to-back throughput is 1 entry/cycle with i_rdy held high.
- o_occ is registered and reflects pushes and pops one cycle after the edge.
- Reset assertion mid-transfer clears the stage immediately, with no credit pulse. Upstream credit counters are reset in the same domain.

## Test plan
- Single push, VC1, data 0xA5, i_rdy=1 -> o_vld=1, o_vc=1, o_data=0xA5 and o_crdt_rtn=2'b10 two cycles after the push, then idle.
- Fill VC0 with 8 pushes under i_rdy=0 -> o_occ[VC0]=7 (one entry already in output stage); ninth and tenth pushes -> o_occ[VC0]=8 then o_ovfl_err=1, o_ovfl_vc=0, data dropped.
- Both VCs loaded with 4 entries, i_rdy=1 -> o_vc alternates 0,1,0,1,... for 8 cycles; each VC sees 4 credit pulses.
- Stall: o_vld=1 with i_rdy=0 for 5 cycles -> o_data and o_vc constant, no credit pulses; then i_rdy=1 -> next entry appears the following cycle.
- Random push/pop for 10k cycles honouring credits (NUM_VC=4, DEPTH=4, DATA_W=32) -> per-VC FIFO ordering preserved, total credits returned = total pushes, o_ovfl_err stays 0.
- Assert mhreset mid-stream, asynchronous to mclk -> all outputs 0 within that cycle, o_occ=0; after release, the first push again returns data with 2-cycle latency.
